// File: rtl/lpm_compare_pkg.sv
// Shared definitions for the multi-channel LPM comparator: flag indices,
// the per-channel flag vector type and the representation names.
package lpm_compare_pkg;

    localparam int ALB    = 0;
    localparam int AEB    = 1;
    localparam int AGB    = 2;
    localparam int ALEB   = 3;
    localparam int ANEB   = 4;
    localparam int AGEB   = 5;
    localparam int FLAG_N = 6;

    typedef logic [FLAG_N-1:0] flag_t;

    localparam string REP_UNSIGNED = "UNSIGNED";
    localparam string REP_SIGNED   = "SIGNED";
    localparam string REP_RUNTIME  = "RUNTIME";

    function automatic bit rep_is_known(input string rep);
        return (rep == REP_UNSIGNED) || (rep == REP_SIGNED) || (rep == REP_RUNTIME);
    endfunction

endpackage

// File: rtl/lpm_compare_mc_if.sv
// Stream interface of lpm_compare_mc: operand beats in, per-channel relation flags out.
interface lpm_compare_mc_if #(
    parameter int lpm_width    = 8,
    parameter int lpm_channels = 4
);

    // Both directions use valid/ready: a beat moves on a rising edge where
    // valid && ready; valid must not wait for ready, and the producer keeps its
    // payload stable until that edge.
    logic                              in_valid;
    logic                              in_ready;
    logic                              is_signed;
    logic [lpm_channels*lpm_width-1:0] dataa;
    logic [lpm_channels*lpm_width-1:0] datab;

    logic                    out_valid;
    logic                    out_ready;
    logic [lpm_channels-1:0] alb;
    logic [lpm_channels-1:0] aeb;
    logic [lpm_channels-1:0] agb;
    logic [lpm_channels-1:0] aleb;
    logic [lpm_channels-1:0] aneb;
    logic [lpm_channels-1:0] ageb;
    logic                    any_agb;
    logic                    all_aeb;

    modport master (
        output in_valid, is_signed, dataa, datab, out_ready,
        input  in_ready, out_valid, alb, aeb, agb, aleb, aneb, ageb, any_agb, all_aeb
    );

    modport slave (
        input  in_valid, is_signed, dataa, datab, out_ready,
        output in_ready, out_valid, alb, aeb, agb, aleb, aneb, ageb, any_agb, all_aeb
    );

endinterface

// File: rtl/lpm_compare_cell.sv
// One-channel combinational magnitude comparator producing the six LPM flags.
module lpm_compare_cell
    import lpm_compare_pkg::*;
#(
    parameter int lpm_width = 8
) (
    input  logic [lpm_width-1:0] a,
    input  logic [lpm_width-1:0] b,
    input  logic                 is_signed,
    output flag_t                flags
);

    logic [lpm_width-1:0] a_key;
    logic [lpm_width-1:0] b_key;
    logic                 lt;
    logic                 eq;

    // Flipping the sign bit maps two's complement order onto unsigned order,
    // so one unsigned comparator serves both modes.
    assign a_key = {a[lpm_width-1] ^ is_signed, a[lpm_width-2:0]};
    assign b_key = {b[lpm_width-1] ^ is_signed, b[lpm_width-2:0]};
    assign lt    = (a_key < b_key);
    assign eq    = (a == b);

    always_comb begin
        flags       = '0;
        flags[ALB]  = lt;
        flags[AEB]  = eq;
        flags[AGB]  = !lt && !eq;
        flags[ALEB] = lt || eq;
        flags[ANEB] = !eq;
        flags[AGEB] = !lt;
    end

endmodule

// File: rtl/lpm_compare_mc.sv
// Pipelined multi-channel comparator: stage 1 registers the cell flags, later
// stages are plain delay registers; the whole pipe stalls on output back-pressure.
module lpm_compare_mc
    import lpm_compare_pkg::*;
#(
    parameter int    lpm_width          = 8,
    parameter int    lpm_channels       = 4,
    parameter int    lpm_pipeline       = 2,
    parameter string lpm_representation = "UNSIGNED"
) (
    input  logic             clock,
    input  logic             sclr,
    input  logic             clken,
    lpm_compare_mc_if.slave  bus
);

    if (lpm_width < 2) begin : g_bad_width
        $error("lpm_compare_mc: lpm_width must be >= 2");
    end
    if (lpm_channels < 1) begin : g_bad_channels
        $error("lpm_compare_mc: lpm_channels must be >= 1");
    end
    if (lpm_pipeline < 1) begin : g_bad_pipeline
        $error("lpm_compare_mc: lpm_pipeline must be >= 1");
    end
    if (!rep_is_known(lpm_representation)) begin : g_bad_rep
        $error("lpm_compare_mc: lpm_representation must be UNSIGNED, SIGNED or RUNTIME");
    end

    localparam bit REP_FIXED_SIGNED = (lpm_representation == REP_SIGNED);
    localparam bit REP_USE_RUNTIME  = (lpm_representation == REP_RUNTIME);

    logic  beat_signed;
    flag_t cell_flags [lpm_channels];

    assign beat_signed = REP_USE_RUNTIME ? bus.is_signed : REP_FIXED_SIGNED;

    for (genvar k = 0; k < lpm_channels; k++) begin : g_cell
        lpm_compare_cell #(
            .lpm_width (lpm_width)
        ) u_cell (
            .a         (bus.dataa[k*lpm_width +: lpm_width]),
            .b         (bus.datab[k*lpm_width +: lpm_width]),
            .is_signed (beat_signed),
            .flags     (cell_flags[k])
        );
    end

    logic [lpm_pipeline-1:0] st_valid;
    flag_t                   st_flags [lpm_pipeline][lpm_channels];
    logic                    adv;
    logic                    out_valid;

    assign out_valid    = st_valid[lpm_pipeline-1];
    assign adv          = clken && !sclr && (!out_valid || bus.out_ready);
    assign bus.in_ready = adv;

    // Stage 0 captures in_valid unconditionally on advance so bubbles travel
    // through the pipe exactly like beats.
    always_ff @(posedge clock) begin
        if (sclr) begin
            st_valid <= '0;
            for (int i = 0; i < lpm_pipeline; i++) begin
                for (int k = 0; k < lpm_channels; k++) begin
                    st_flags[i][k] <= '0;
                end
            end
        end else if (adv) begin
            st_valid[0] <= bus.in_valid;
            for (int k = 0; k < lpm_channels; k++) begin
                st_flags[0][k] <= cell_flags[k];
            end
            for (int i = 1; i < lpm_pipeline; i++) begin
                st_valid[i] <= st_valid[i-1];
                for (int k = 0; k < lpm_channels; k++) begin
                    st_flags[i][k] <= st_flags[i-1][k];
                end
            end
        end
    end

    logic [lpm_channels-1:0] res_alb;
    logic [lpm_channels-1:0] res_aeb;
    logic [lpm_channels-1:0] res_agb;
    logic [lpm_channels-1:0] res_aleb;
    logic [lpm_channels-1:0] res_aneb;
    logic [lpm_channels-1:0] res_ageb;

    // Flags of an empty output stage are meaningless, so they are masked to 0.
    always_comb begin
        res_alb  = '0;
        res_aeb  = '0;
        res_agb  = '0;
        res_aleb = '0;
        res_aneb = '0;
        res_ageb = '0;
        if (out_valid) begin
            for (int k = 0; k < lpm_channels; k++) begin
                res_alb[k]  = st_flags[lpm_pipeline-1][k][ALB];
                res_aeb[k]  = st_flags[lpm_pipeline-1][k][AEB];
                res_agb[k]  = st_flags[lpm_pipeline-1][k][AGB];
                res_aleb[k] = st_flags[lpm_pipeline-1][k][ALEB];
                res_aneb[k] = st_flags[lpm_pipeline-1][k][ANEB];
                res_ageb[k] = st_flags[lpm_pipeline-1][k][AGEB];
            end
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.alb       = res_alb;
    assign bus.aeb       = res_aeb;
    assign bus.agb       = res_agb;
    assign bus.aleb      = res_aleb;
    assign bus.aneb      = res_aneb;
    assign bus.ageb      = res_ageb;
    assign bus.any_agb   = |res_agb;
    assign bus.all_aeb   = out_valid && (&res_aeb);

endmodule

// File: doc/lpm_compare_mc.md
# lpm_compare_mc

Multi-channel, pipelined magnitude comparator with valid/ready flow control and per-beat signed/unsigned selection. Each accepted beat carries `lpm_channels` independent operand pairs. The block produces the six LPM relation flags per channel, plus two cross-channel reductions, after a fixed `lpm_pipeline` cycles. It sits between streaming datapath stages that need back-pressure-aware comparison, such as threshold checks and sort/merge units.

## Interface
- `lpm_width`, 8: operand width per channel; must be ≥ 2.
- `lpm_channels`, 4: number of operand pairs per beat; must be ≥ 1.
- `lpm_pipeline`, 2: latency in register stages; must be ≥ 1.
- `lpm_representation`, "UNSIGNED": one of "UNSIGNED", "SIGNED" or "RUNTIME". Any other value reports an error at elaboration.
- `clock`  in  1  sole clock; all logic on its rising edge.
- `sclr`  in  1  reset; synchronous, active-high. It has priority over every other input.
- `clken`  in  1  clock enable; low freezes all state.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  input beat is accepted this cycle when `in_valid && in_ready`.
- `is_signed`  in  1  per-beat mode; used only when `lpm_representation` is "RUNTIME".
- `dataa`, `datab`  in  `lpm_channels*lpm_width`  packed operands; channel k occupies bits `[k*lpm_width +: lpm_width]`.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  the consumer takes the result.
- `alb`, `aeb`, `agb`, `aleb`, `aneb`, `ageb`  out  `lpm_channels`  relation flags per channel.
- `any_agb`  out  1  OR of `agb` across all channels.
- `all_aeb`  out  1  AND of `aeb` across all channels.

## Operation
- Signedness is taken from `lpm_representation` unless it is "RUNTIME", in which case it is taken from `is_signed` sampled with the beat.
- Signed operands are two's complement. Unsigned operands are plain binary.
- No widening is needed; the comparison is exact at `lpm_width`.
- Stage 1 registers the flags computed from the accepted inputs. Stages 2..`lpm_pipeline` are delay registers, each with its own valid bit.
- Advance condition: `adv = clken && !sclr && (!out_valid || out_ready)`.
- When `adv` is high, every stage shifts by one. Stage 1 loads `in_valid` together with the flags.
- The pipeline stalls as a whole. Bubbles are not collapsed.
- `in_ready = adv`. It is combinational from `clken`, `sclr`, `out_valid` and `out_ready`. There is no path from `in_valid` to `in_ready`.
- While `out_valid` is high and `out_ready` is low, all outputs hold stable.
- The flags of a stage whose valid bit is 0 are don't-care internally. At the outputs, every flag and reduction is forced to 0 whenever `out_valid` is 0.
- On `sclr`, all stage valid bits and all flag registers clear to 0. This also discards in-flight beats; none are emitted later.
- Reset values: `out_valid`=0, all flags=0, `any_agb`=0, `all_aeb`=0. `in_ready` is 0 while `sclr` is high.
- With `clken` low, no state changes, `in_ready`=0, and outputs hold.

## Timing
- Latency: a beat accepted at edge t appears at `out_valid` after edge t+`lpm_pipeline`-1. This means 1 cycle when `lpm_pipeline`=1, with no stall.
- Throughput: one beat per cycle while `out_ready` is high and `clken` is high.
- `out_ready` low with `out_valid` high stalls the pipeline. `in_ready` drops in the same cycle.
- Simultaneous output pop and input accept in the same cycle is allowed and loses nothing.
- `sclr` and `in_valid` asserted together: the beat is not accepted.
- If `sclr` is released while `in_valid` is high, acceptance resumes on the next cycle.

## Structure
- Shared package `lpm_compare_pkg`:
  - Constants for flag indices: ALB=0, AEB=1, AGB=2, ALEB=3, ANEB=4, AGEB=5.
  - A 6-bit flag-vector typedef.
  - The representation string constants.
- Sub-module `lpm_compare_cell`: combinational, one channel. It takes `a`, `b` and `is_signed` and returns the 6-bit flag vector. It is instantiated `lpm_channels` times.
- The top level holds the stage registers, valid chain, handshake and reductions.

## Test plan
Configuration: `lpm_width`=8, `lpm_channels`=4, `lpm_pipeline`=2, "RUNTIME" unless stated.

- **Reset:** hold `sclr` for 2 cycles with `in_valid`=1 → `out_valid`=0, all flags 0, `in_ready`=0. One cycle after release, `in_ready`=1.
- **Signedness:** send ch0 a=0x80, b=0x7F with `is_signed`=0 → `agb[0]`=1, `ageb[0]`=1, `aneb[0]`=1. The same operands with `is_signed`=1 → `alb[0]`=1, `aleb[0]`=1. Each result appears 2 cycles after acceptance.
- **Equality, extremes and reductions:**
  - All channels a=b=0xFF → `aeb`=4'hF, `aleb`=4'hF, `ageb`=4'hF, `all_aeb`=1, `any_agb`=0.
  - Ch2 signed a=0x00, b=0xFF → `agb[2]`=1, `any_agb`=1, `all_aeb`=0.
- **Back-pressure:** stream 6 beats, then hold `out_ready`=0 for 3 cycles → `in_ready`=0 during the stall, outputs stable, all 6 results delivered in order with no loss or duplication.
- **Clock enable:** drop `clken` for 2 cycles mid-stream → no state change, `in_ready`=0. The stream resumes exactly where it stopped.
- **Reset mid-flight:** assert `sclr` for 1 cycle with 2 beats in flight → neither beat is ever emitted, `out_valid`=0 the next cycle, and the next accepted beat emerges with latency 2.
